// File: rtl/rr_sel_arbiter_if.sv
// rr_sel_arbiter_if: request/handshake bundle between the sources, the arbiter and the mux select.
interface rr_sel_arbiter_if;
  logic [3:0] req;
  logic       ready;
  logic [1:0] sel;
  logic [3:0] grant;
  logic       valid;
  modport master (output req, ready, input sel, grant, valid);
  modport slave  (input req, ready, output sel, grant, valid);
endinterface

// File: rtl/rr_sel_arbiter.sv
// rr_sel_arbiter: round-robin 4-source arbiter driving the mux_4to1 select, grants held per burst.
// Define RR_ARB_TIMEOUT_EN to cap each grant at MAX_HOLD transfers.
module rr_sel_arbiter
`ifdef RR_ARB_TIMEOUT_EN
  #(parameter int MAX_HOLD = 8)
`endif
  (
  input  logic            clk,
  input  logic            rst_n,
  rr_sel_arbiter_if.slave bus
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t     state_q, state_d;
  logic [1:0] sel_q, sel_d, last_ptr_q, last_ptr_d, win;
  logic [3:0] grant_q, grant_d;
  logic       win_any, xfer, rearb;
  assign bus.sel   = sel_q;
  assign bus.grant = grant_q;
  assign bus.valid = (state_q == GRANT) && bus.req[sel_q];
  assign xfer      = bus.valid && bus.ready;
  assign win_any   = |bus.req;
  // Scan downward so the nearest source after last_ptr wins; the holder itself is offset 4, i.e. last.
  always_comb begin
    win = last_ptr_q;
    for (int k = 4; k >= 1; k--)
      if (bus.req[2'(last_ptr_q + 2'(k))]) win = 2'(last_ptr_q + 2'(k));
  end
`ifdef RR_ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD);
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          timeout;
  assign timeout    = xfer && (hold_cnt_q == HW'(MAX_HOLD - 1));
  assign rearb      = (state_q == IDLE) || !bus.req[sel_q] || timeout;
  assign hold_cnt_d = rearb ? '0 : hold_cnt_q + HW'(xfer);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) hold_cnt_q <= '0;
    else        hold_cnt_q <= hold_cnt_d;
`else
  assign rearb = (state_q == IDLE) || !bus.req[sel_q];
`endif
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    grant_d    = grant_q;
    last_ptr_d = last_ptr_q;
    if (rearb) begin
      state_d    = win_any ? GRANT : IDLE;
      sel_d      = win_any ? win : sel_q;
      grant_d    = win_any ? 4'b0001 << win : 4'b0000;
      last_ptr_d = win_any ? win : last_ptr_q;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= IDLE;
      sel_q      <= 2'd0;
      grant_q    <= 4'b0000;
      last_ptr_q <= 2'd3;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      grant_q    <= grant_d;
      last_ptr_q <= last_ptr_d;
    end
endmodule

// File: tb/tb_rr_sel_arbiter.sv
// tb_rr_sel_arbiter: directed scoreboard bench for the round-robin mux-select arbiter.
module tb_rr_sel_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  logic [6:0] exp_q[$];
  rr_sel_arbiter_if bus();
  rr_sel_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [6:0] pk(input int s, input logic [3:0] g, input logic v);
    return {2'(s), g, v};
  endfunction
  task automatic compare(input string tag);
    logic [6:0] e, a;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $error("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = exp_q.pop_front();
    a = {bus.sel, bus.grant, bus.valid};
    assert (a === e) else begin
      miscompares++;
      $error("FAIL %s: observed sel=%0d grant=%b valid=%b, expected sel=%0d grant=%b valid=%b",
             tag, a[6:5], a[4:1], a[0], e[6:5], e[4:1], e[0]);
    end
  endtask
  task automatic apply(input logic [3:0] r, input logic rd, input int s, input logic [3:0] g,
                       input logic v, input string tag);
    bus.req = r;
    bus.ready = rd;
    exp_q.push_back(pk(s, g, v));
    #1 compare(tag);
  endtask
  task automatic tick(input int s, input logic [3:0] g, input logic v, input string tag);
    exp_q.push_back(pk(s, g, v));
    @(posedge clk);
    #1 compare(tag);
  endtask
  task automatic async_reset(input string tag);
    exp_q.push_back(pk(0, 4'b0000, 1'b0));
    rst_n = 1'b0;
    #1 compare(tag);
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask
  initial begin
    bus.req = 4'b0000;
    bus.ready = 1'b0;
    #2 async_reset("reset");
    for (int i = 0; i < 5; i++) tick(0, 4'b0000, 1'b0, "idle_no_req");
    apply(4'b0101, 1'b1, 0, 4'b0000, 1'b0, "idle_pre_grant");
    tick(0, 4'b0001, 1'b1, "first_grant_src0");
    tick(0, 4'b0001, 1'b1, "hold_src0");
    apply(4'b0100, 1'b1, 0, 4'b0001, 1'b0, "drop_src0_valid_low");
    tick(2, 4'b0100, 1'b1, "regrant_src2");
    apply(4'b1111, 1'b1, 2, 4'b0100, 1'b1, "all_req_holder_kept");
    tick(2, 4'b0100, 1'b1, "burst_src2");
    apply(4'b1011, 1'b1, 2, 4'b0100, 1'b0, "drop_src2");
    tick(3, 4'b1000, 1'b1, "rr_next_src3");
    apply(4'b0011, 1'b1, 3, 4'b1000, 1'b0, "drop_src3");
    tick(0, 4'b0001, 1'b1, "rr_wrap_src0");
    apply(4'b0010, 1'b1, 0, 4'b0001, 1'b0, "drop_src0_again");
    tick(1, 4'b0010, 1'b1, "grant_src1");
    apply(4'b0010, 1'b0, 1, 4'b0010, 1'b1, "stall_start");
    for (int i = 0; i < 6; i++) tick(1, 4'b0010, 1'b1, "stall_hold");
    apply(4'b0010, 1'b1, 1, 4'b0010, 1'b1, "stall_release");
    for (int i = 0; i < 2; i++) tick(1, 4'b0010, 1'b1, "resume_src1");
    apply(4'b0000, 1'b1, 1, 4'b0010, 1'b0, "all_drop");
    tick(1, 4'b0000, 1'b0, "to_idle_sel_kept");
    tick(1, 4'b0000, 1'b0, "idle_stays");
    apply(4'b1010, 1'b1, 1, 4'b0000, 1'b0, "idle_new_req");
    tick(3, 4'b1000, 1'b1, "search_after_src1");
    apply(4'b0100, 1'b1, 3, 4'b1000, 1'b0, "handover_to_src2");
    tick(2, 4'b0100, 1'b1, "grant_src2_burst");
    async_reset("async_reset_mid_burst");
    apply(4'b1111, 1'b1, 0, 4'b0000, 1'b0, "post_reset_idle");
    tick(0, 4'b0001, 1'b1, "post_reset_src0_first");
    for (int i = 0; i < 5; i++) tick(0, 4'b0001, 1'b1, "all_req_sel_stays0");
`ifdef RR_ARB_TIMEOUT_EN
    apply(4'b0000, 1'b1, 0, 4'b0001, 1'b0, "prep_timeout");
    async_reset("reset_for_timeout");
    apply(4'b1111, 1'b1, 0, 4'b0000, 1'b0, "timeout_start");
    for (int g = 0; g < 5; g++)
      for (int k = 0; k < 8; k++) tick(g % 4, 4'b0001 << (g % 4), 1'b1, "timeout_rotation");
    async_reset("reset_for_sole");
    apply(4'b1000, 1'b1, 0, 4'b0000, 1'b0, "sole_start");
    for (int i = 0; i < 20; i++) tick(3, 4'b1000, 1'b1, "sole_src3_regrant");
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
